// File: rtl/bcd_converter_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// Used by the interface, the top and the per-digit adjust cell.
package bcd_converter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] NIB_THRESH = 4'd5;
  localparam logic [3:0] NIB_CORR   = 4'd3;

  // Decimal digits needed for the largest width-bit value, i.e. ceil(width*log10(2)).
  function automatic int bcd_digits_for(input int width);
    longint unsigned max_val;
    int              d;
    max_val = (64'd1 << width) - 64'd1;
    d = 1;
    while (max_val >= 64'd10) begin
      max_val = max_val / 64'd10;
      d++;
    end
    return d;
  endfunction

endpackage

// File: rtl/bcd_converter_seq_if.sv
// Handshake bundle between a binary producer, the converter and a display consumer.
// master = producer/consumer side, slave = converter side.
interface bcd_converter_seq_if #(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5
);
  logic [BIN_W-1:0]    Binary;
  logic                in_valid;
  logic                in_ready;
  logic [4*DIGITS-1:0] BCD;
  logic [DIGITS-1:0]   Blank;
  logic                out_valid;
  logic                out_ready;

  modport master (
    output Binary, in_valid, out_ready,
    input  in_ready, BCD, Blank, out_valid
  );

  modport slave (
    input  Binary, in_valid, out_ready,
    output in_ready, BCD, Blank, out_valid
  );
endinterface

// File: rtl/bcd_digit_adjust.sv
// Add-3 correction for one BCD nibble before the next left shift.
module bcd_digit_adjust
  import bcd_converter_pkg::*;
(
  input  logic [3:0] digit,
  output logic [3:0] corrected
);
  assign corrected = (digit >= NIB_THRESH) ? digit + NIB_CORR : digit;
endmodule

// File: rtl/bcd_converter_seq.sv
// Shift-and-add-3 binary-to-BCD converter, one input bit per clock, with
// valid/ready handshakes and a registered leading-zero blank mask.
module bcd_converter_seq
  import bcd_converter_pkg::*;
#(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5
) (
  input logic               clk,
  input logic               rst_n,
  bcd_converter_seq_if.slave bus
);
  localparam int SCR_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

  generate
    if (BIN_W < 1 || BIN_W > 32) begin : g_bad_width
      $error("bcd_converter_seq: BIN_W out of range 1..32");
    end
    if (DIGITS < bcd_digits_for(BIN_W)) begin : g_bad_digits
      $error("bcd_converter_seq: DIGITS too small for BIN_W");
    end
  endgenerate

  state_t              state_reg, state_next;
  logic [BIN_W-1:0]    shift_reg, shift_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic [SCR_W-1:0]    scratch_reg, scratch_next;
  logic [SCR_W-1:0]    bcd_reg, bcd_next;
  logic [DIGITS-1:0]   blank_reg, blank_next;

  logic [SCR_W-1:0]    adjusted;
  logic [SCR_W-1:0]    scratch_shift;
  logic [BIN_W-1:0]    shift_shift;
  logic [DIGITS-1:0]   nibble_zero;
  logic [DIGITS-1:0]   blank_calc;
  logic                ready;
  logic                accept;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_adjust
      bcd_digit_adjust u_adjust (
        .digit     (scratch_reg[4*gi +: 4]),
        .corrected (adjusted[4*gi +: 4])
      );
      assign nibble_zero[gi] = (scratch_shift[4*gi +: 4] == 4'd0);
    end

    // A digit is blanked only when it and every more significant digit are zero.
    assign blank_calc[0] = 1'b0;
    for (gi = 1; gi < DIGITS; gi++) begin : g_blank
      assign blank_calc[gi] = &nibble_zero[DIGITS-1:gi];
    end
  endgenerate

  assign {scratch_shift, shift_shift} = {adjusted, shift_reg} << 1;

  assign ready  = (state_reg == IDLE) || ((state_reg == DONE) && bus.out_ready);
  assign accept = ready && bus.in_valid;

  always_comb begin
    state_next   = state_reg;
    shift_next   = shift_reg;
    cnt_next     = cnt_reg;
    scratch_next = scratch_reg;
    bcd_next     = bcd_reg;
    blank_next   = blank_reg;
    case (state_reg)
      IDLE, DONE: begin
        if (accept) begin
          shift_next   = bus.Binary;
          cnt_next     = '0;
          scratch_next = '0;
          state_next   = CONV;
        end else if (state_reg == DONE && bus.out_ready) begin
          state_next = IDLE;
        end
      end
      CONV: begin
        shift_next   = shift_shift;
        scratch_next = scratch_shift;
        cnt_next     = cnt_reg + CNT_W'(1);
        if (cnt_reg == LAST_CNT) begin
          bcd_next   = scratch_shift;
          blank_next = blank_calc;
          state_next = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      shift_reg   <= '0;
      cnt_reg     <= '0;
      scratch_reg <= '0;
      bcd_reg     <= '0;
      blank_reg   <= '0;
    end else begin
      state_reg   <= state_next;
      shift_reg   <= shift_next;
      cnt_reg     <= cnt_next;
      scratch_reg <= scratch_next;
      bcd_reg     <= bcd_next;
      blank_reg   <= blank_next;
    end
  end

  assign bus.in_ready  = ready;
  assign bus.out_valid = (state_reg == DONE);
  assign bus.BCD       = bcd_reg;
  assign bus.Blank     = blank_reg;

endmodule

// File: tb/tb_bcd_converter_seq.sv
// Directed bench for bcd_converter_seq: 16-bit/5-digit vectors, handshake
// corner cases, async reset abort, and a full 7-bit/3-digit sweep.
module tb_bcd_converter_seq;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  bcd_converter_seq_if #(.BIN_W(16), .DIGITS(5)) bus16 ();
  bcd_converter_seq_if #(.BIN_W(7),  .DIGITS(3)) bus7 ();

  bcd_converter_seq #(.BIN_W(16), .DIGITS(5)) dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus16.slave)
  );

  bcd_converter_seq #(.BIN_W(7), .DIGITS(3)) dut7 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus7.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] bin;
    logic [19:0] bcd;
    logic [4:0]  blank;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Launch one 16-bit conversion and wait for the result; leaves DUT in DONE.
  task automatic conv16(input logic [15:0] bin, input logic [19:0] exp_bcd,
                        input logic [4:0] exp_blank);
    int lat;
    bus16.Binary    = bin;
    bus16.in_valid  = 1'b1;
    bus16.out_ready = 1'b0;
    check("in_ready_idle16", 32'(bus16.in_ready), 32'd1);
    @(posedge clk); #1;
    bus16.in_valid = 1'b0;
    lat = 0;
    while (!bus16.out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency16", 32'(lat), 32'd16);
    check("bcd16", 32'(bus16.BCD), 32'(exp_bcd));
    check("blank16", 32'(bus16.Blank), 32'(exp_blank));
    $display("conv16 bin=%0d bcd=%05h blank=%05b latency=%0d", bin, bus16.BCD, bus16.Blank, lat);
  endtask

  task automatic release16();
    bus16.out_ready = 1'b1;
    #1;
    check("in_ready_done16", 32'(bus16.in_ready), 32'd1);
    @(posedge clk); #1;
    check("idle_after_take16", 32'(bus16.out_valid), 32'd0);
    bus16.out_ready = 1'b0;
  endtask

  task automatic run7(input logic [6:0] bin, input logic [11:0] exp_bcd,
                      input logic [2:0] exp_blank);
    int lat;
    bus7.Binary    = bin;
    bus7.in_valid  = 1'b1;
    bus7.out_ready = 1'b0;
    @(posedge clk); #1;
    bus7.in_valid = 1'b0;
    lat = 0;
    while (!bus7.out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency7", 32'(lat), 32'd7);
    check("bcd7", 32'(bus7.BCD), 32'(exp_bcd));
    check("blank7", 32'(bus7.Blank), 32'(exp_blank));
    $display("conv7 bin=%0d bcd=%03h blank=%03b latency=%0d", bin, bus7.BCD, bus7.Blank, lat);
    bus7.out_ready = 1'b1;
    @(posedge clk); #1;
    bus7.out_ready = 1'b0;
  endtask

  initial begin
    logic [15:0] b2b_in[3];
    logic [19:0] b2b_exp[3];
    int          cyc;
    int          nres;
    int          nxt;
    bit          adv;
    bit          saw_valid;

    checks   = 0;
    failures = 0;

    vecs[0] = '{16'd0,     20'h00000, 5'b11110};
    vecs[1] = '{16'd65535, 20'h65535, 5'b00000};
    vecs[2] = '{16'd1000,  20'h01000, 5'b10000};
    vecs[3] = '{16'd9,     20'h00009, 5'b11110};
    vecs[4] = '{16'd10,    20'h00010, 5'b11100};
    vecs[5] = '{16'd100,   20'h00100, 5'b11000};
    vecs[6] = '{16'd12345, 20'h12345, 5'b00000};
    vecs[7] = '{16'd42,    20'h00042, 5'b11100};
    vecs[8] = '{16'd59999, 20'h59999, 5'b00000};
    vecs[9] = '{16'd1,     20'h00001, 5'b11110};

    b2b_in[0]  = 16'd9;     b2b_exp[0] = 20'h00009;
    b2b_in[1]  = 16'd10;    b2b_exp[1] = 20'h00010;
    b2b_in[2]  = 16'd59999; b2b_exp[2] = 20'h59999;

    rst_n           = 1'b0;
    bus16.Binary    = '0;
    bus16.in_valid  = 1'b0;
    bus16.out_ready = 1'b0;
    bus7.Binary     = '0;
    bus7.in_valid   = 1'b0;
    bus7.out_ready  = 1'b0;

    #1;
    check("rst_in_ready", 32'(bus16.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus16.out_valid), 32'd0);
    check("rst_bcd", 32'(bus16.BCD), 32'd0);
    check("rst_blank", 32'(bus16.Blank), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      conv16(vecs[i].bin, vecs[i].bcd, vecs[i].blank);
      release16();
    end

    // Backpressure: result must hold and input must stall while out_ready is low.
    conv16(16'd1234, 20'h01234, 5'b10000);
    bus16.in_valid = 1'b1;
    bus16.Binary   = 16'd777;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp_bcd_hold", 32'(bus16.BCD), 32'h01234);
      check("bp_in_ready", 32'(bus16.in_ready), 32'd0);
      check("bp_out_valid", 32'(bus16.out_valid), 32'd1);
    end
    bus16.in_valid = 1'b0;
    release16();
    $display("backpressure hold 10 cycles done");

    // Back-to-back: in_valid held high, results every 17 cycles.
    bus16.out_ready = 1'b1;
    bus16.Binary    = b2b_in[0];
    bus16.in_valid  = 1'b1;
    @(posedge clk); #1;
    bus16.Binary = b2b_in[1];
    cyc  = 0;
    nres = 0;
    nxt  = 2;
    adv  = 1'b0;
    while (nres < 3 && cyc < 80) begin
      @(posedge clk); #1;
      cyc++;
      if (adv) begin
        if (nxt < 3) bus16.Binary = b2b_in[nxt];
        nxt++;
        adv = 1'b0;
      end
      if (bus16.out_valid) begin
        check("b2b_bcd", 32'(bus16.BCD), 32'(b2b_exp[nres]));
        check("b2b_cycle", 32'(cyc), 32'(17 * nres + 16));
        $display("b2b result=%05h cycle=%0d", bus16.BCD, cyc);
        nres++;
        adv = 1'b1;
        if (nres == 3) bus16.in_valid = 1'b0;
      end
    end
    check("b2b_count", 32'(nres), 32'd3);
    @(posedge clk); #1;
    check("b2b_idle", 32'(bus16.out_valid), 32'd0);
    bus16.out_ready = 1'b0;

    // Async reset during CONV cycle 7 aborts with no partial output.
    bus16.Binary   = 16'd1234;
    bus16.in_valid = 1'b1;
    @(posedge clk); #1;
    bus16.in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", 32'(bus16.out_valid), 32'd0);
    check("abort_bcd", 32'(bus16.BCD), 32'd0);
    check("abort_blank", 32'(bus16.Blank), 32'd0);
    check("abort_in_ready", 32'(bus16.in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    saw_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (bus16.out_valid) saw_valid = 1'b1;
    end
    check("abort_no_result", 32'(saw_valid), 32'd0);
    $display("reset abort mid-conversion done");
    conv16(16'd42, 20'h00042, 5'b11100);
    release16();

    // Full sweep of the 7-bit / 3-digit instance against a decimal reference.
    for (int v = 0; v < 128; v++) begin
      int d2, d1, d0;
      logic [11:0] exp_bcd;
      logic [2:0]  exp_blank;
      d2 = v / 100;
      d1 = (v / 10) % 10;
      d0 = v % 10;
      exp_bcd   = {d2[3:0], d1[3:0], d0[3:0]};
      exp_blank = {d2 == 0, (d2 == 0) && (d1 == 0), 1'b0};
      run7(7'(v), exp_bcd, exp_blank);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
